// File: rtl/ttt_pkg.sv
// ttt_pkg: shared encodings and helpers for the tic-tac-toe grid controller.
//   - mark_e       : per-cell mark encoding (empty / X / O)
//   - game_state_e : controller FSM states as seen on the game_state port
//   - cell_idx()   : flattens (row, col) into a row-major cell index
package ttt_pkg;

    typedef enum logic [1:0] {
        MARK_EMPTY = 2'b00,
        MARK_X     = 2'b01,
        MARK_O     = 2'b10
    } mark_e;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_CHECK = 2'b01,
        ST_WIN   = 2'b10,
        ST_DRAW  = 2'b11
    } game_state_e;

    // Row-major flattening; the board stores cell i in bits [2*i +: 2].
    function automatic int cell_idx(input int row, input int col, input int grid);
        return row * grid + col;
    endfunction

endpackage

// File: rtl/ttt_line_checker.sv
// ttt_line_checker: combinational win detector for a GRID x GRID board.
//   board : flattened board, cell (r,c) at bits [2*(r*GRID+c) +: 2]
//   mark  : mark of the player being tested (MARK_X or MARK_O)
//   win   : 1 when any full row, column or diagonal holds only that mark
module ttt_line_checker
    import ttt_pkg::*;
#(
    parameter int GRID = 3
) (
    input  logic [2*GRID*GRID-1:0] board,
    input  logic [1:0]             mark,
    output logic                   win
);

    logic [GRID*GRID-1:0] match;
    logic [GRID-1:0]      row_win;
    logic [GRID-1:0]      col_win;
    logic [GRID-1:0]      diag_bits;
    logic [GRID-1:0]      anti_bits;

    for (genvar i = 0; i < GRID * GRID; i++) begin : g_match
        assign match[i] = (board[2*i +: 2] == mark);
    end

    for (genvar r = 0; r < GRID; r++) begin : g_line
        logic [GRID-1:0] row_bits;
        logic [GRID-1:0] col_bits;
        for (genvar c = 0; c < GRID; c++) begin : g_cell
            assign row_bits[c] = match[r*GRID + c];
            assign col_bits[c] = match[c*GRID + r];
        end
        assign row_win[r]   = &row_bits;
        assign col_win[r]   = &col_bits;
        assign diag_bits[r] = match[r*GRID + r];
        assign anti_bits[r] = match[r*GRID + (GRID - 1 - r)];
    end

    // An empty "mark" would match an empty board; never report that as a win.
    assign win = (mark != MARK_EMPTY) &&
                 ((|row_win) || (|col_win) || (&diag_bits) || (&anti_bits));

endmodule

// File: rtl/ttt_grid_controller.sv
// ttt_grid_controller: game-state controller for the VGA tic-tac-toe board.
//   clk, rst                    : system clock, async active-high reset
//   up/down/left/right/sel/restart : debounced button levels (edge-detected here)
//   rd_row, rd_col -> rd_mark   : combinational cell read port for the renderer
//   cur_row, cur_col            : cursor cell
//   turn                        : 0 = X to move, 1 = O to move
//   game_state                  : PLAY / CHECK / WIN / DRAW
//   winner                      : winning mark, 00 unless in WIN
//   move_count                  : marks placed so far
//   invalid                     : one-cycle pulse after sel on an occupied cell
module ttt_grid_controller
    import ttt_pkg::*;
#(
    parameter int GRID  = 3,
    parameter int IDX_W = $clog2(GRID),
    parameter int CNT_W = $clog2(GRID*GRID+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             sel,
    input  logic             restart,
    input  logic [IDX_W-1:0] rd_row,
    input  logic [IDX_W-1:0] rd_col,
    output logic [1:0]       rd_mark,
    output logic [IDX_W-1:0] cur_row,
    output logic [IDX_W-1:0] cur_col,
    output logic             turn,
    output logic [1:0]       game_state,
    output logic [1:0]       winner,
    output logic [CNT_W-1:0] move_count,
    output logic             invalid
);

    localparam int                 Cells    = GRID * GRID;
    localparam logic [IDX_W-1:0]   IdxMax   = IDX_W'(GRID - 1);
    localparam logic [IDX_W-1:0]   IdxMid   = IDX_W'(GRID / 2);
    localparam logic [CNT_W-1:0]   CntFull  = CNT_W'(Cells);

    // Button bit positions inside the sync/history vectors.
    localparam int BtnRight   = 0;
    localparam int BtnLeft    = 1;
    localparam int BtnUp      = 2;
    localparam int BtnDown    = 3;
    localparam int BtnSel     = 4;
    localparam int BtnRestart = 5;

    logic [5:0]         btn_sync_q, btn_sync_d;
    logic [5:0]         btn_prev_q, btn_prev_d;
    logic [5:0]         press;
    logic [2*Cells-1:0] board_q, board_d;
    logic [IDX_W-1:0]   cur_row_q, cur_row_d;
    logic [IDX_W-1:0]   cur_col_q, cur_col_d;
    logic               turn_q, turn_d;
    game_state_e        state_q, state_d;
    logic [1:0]         winner_q, winner_d;
    logic [CNT_W-1:0]   move_count_q, move_count_d;
    logic               invalid_q, invalid_d;

    logic [1:0]         player_mark;
    logic               player_wins;
    int                 cur_idx;

    // One sync stage plus a history stage: a press is seen on the cycle after the
    // input rises and acts on the following edge.
    assign btn_sync_d = {restart, sel, down, up, left, right};
    assign btn_prev_d = btn_sync_q;
    assign press      = btn_sync_q & ~btn_prev_q;

    assign player_mark = turn_q ? MARK_O : MARK_X;
    assign cur_idx     = cell_idx(int'(cur_row_q), int'(cur_col_q), GRID);

    ttt_line_checker #(
        .GRID (GRID)
    ) u_line_checker (
        .board (board_q),
        .mark  (player_mark),
        .win   (player_wins)
    );

    always_comb begin
        board_d      = board_q;
        cur_row_d    = cur_row_q;
        cur_col_d    = cur_col_q;
        turn_d       = turn_q;
        state_d      = state_q;
        winner_d     = winner_q;
        move_count_d = move_count_q;
        invalid_d    = 1'b0;

        if (press[BtnRestart]) begin
            board_d      = '0;
            cur_row_d    = IdxMid;
            cur_col_d    = IdxMid;
            turn_d       = 1'b0;
            state_d      = ST_PLAY;
            winner_d     = MARK_EMPTY;
            move_count_d = '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (press[BtnSel]) begin
                        if (board_q[2*cur_idx +: 2] == MARK_EMPTY) begin
                            board_d[2*cur_idx +: 2] = player_mark;
                            move_count_d            = move_count_q + 1'b1;
                            state_d                 = ST_CHECK;
                        end else begin
                            invalid_d = 1'b1;
                        end
                    end else if (press[BtnRight]) begin
                        cur_col_d = (cur_col_q == IdxMax) ? '0 : cur_col_q + 1'b1;
                    end else if (press[BtnLeft]) begin
                        cur_col_d = (cur_col_q == '0) ? IdxMax : cur_col_q - 1'b1;
                    end else if (press[BtnUp]) begin
                        cur_row_d = (cur_row_q == '0) ? IdxMax : cur_row_q - 1'b1;
                    end else if (press[BtnDown]) begin
                        cur_row_d = (cur_row_q == IdxMax) ? '0 : cur_row_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    // turn_q still names the player who just moved.
                    if (player_wins) begin
                        state_d  = ST_WIN;
                        winner_d = player_mark;
                    end else if (move_count_q == CntFull) begin
                        state_d = ST_DRAW;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = ST_PLAY;
                    end
                end
                default: ;  // WIN and DRAW are frozen until restart
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync_q   <= '0;
            btn_prev_q   <= '0;
            board_q      <= '0;
            cur_row_q    <= IdxMid;
            cur_col_q    <= IdxMid;
            turn_q       <= 1'b0;
            state_q      <= ST_PLAY;
            winner_q     <= MARK_EMPTY;
            move_count_q <= '0;
            invalid_q    <= 1'b0;
        end else begin
            btn_sync_q   <= btn_sync_d;
            btn_prev_q   <= btn_prev_d;
            board_q      <= board_d;
            cur_row_q    <= cur_row_d;
            cur_col_q    <= cur_col_d;
            turn_q       <= turn_d;
            state_q      <= state_d;
            winner_q     <= winner_d;
            move_count_q <= move_count_d;
            invalid_q    <= invalid_d;
        end
    end

    always_comb begin
        rd_mark = MARK_EMPTY;
        if (int'(rd_row) < GRID && int'(rd_col) < GRID) begin
            rd_mark = board_q[2*cell_idx(int'(rd_row), int'(rd_col), GRID) +: 2];
        end
    end

    assign cur_row    = cur_row_q;
    assign cur_col    = cur_col_q;
    assign turn       = turn_q;
    assign game_state = state_q;
    assign winner     = winner_q;
    assign move_count = move_count_q;
    assign invalid    = invalid_q;

endmodule
